// File: rtl/video_meter_pkg.sv
// Shared types and constants for the video stream meter.
package video_meter_pkg;

    typedef enum logic {
        WAIT_VS,
        MEASURE
    } meter_state_t;

    localparam int ERR_WIDTH = 0;
    localparam int ERR_SAT   = 1;
    localparam int ERR_VS    = 2;
    localparam int ERR_BITS  = 3;

endpackage

// File: rtl/video_meter_satcnt.sv
// Saturating up-counter with priority load; o_sat is high while the count sits at its maximum.
module video_meter_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] r_cnt;

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = &r_cnt;

endmodule

// File: rtl/video_stream_meter.sv
// Passive pixel-stream monitor: per-frame geometry, line period, pixel sum, anomaly flags and lock.
module video_stream_meter
    import video_meter_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 12,
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [CNT_WIDTH-1:0]   width_o,
    output logic [CNT_WIDTH-1:0]   height_o,
    output logic [CNT_WIDTH-1:0]   line_clk_o,
    output logic [31:0]            sum_o,
    output logic [15:0]            frame_cnt_o,
    output logic [ERR_BITS-1:0]    err_o,
    output logic                   update_o,
    output logic                   locked_o
);

    localparam int SW = $clog2(STABLE_FRAMES + 1);

    meter_state_t r_state, w_state_next;

    logic                 w_ls, w_fs, w_vs_err, w_measure, w_restart, w_first_line;
    logic                 w_pix_sat, w_line_sat, w_clk_sat, w_same_geom;
    logic [CNT_WIDTH-1:0] w_pix_cnt, w_line_cnt, w_clk_cnt;
    logic [CNT_WIDTH-1:0] w_close_width, w_close_period;
    logic [ERR_BITS-1:0]  w_err_next;

    logic [CNT_WIDTH-1:0] r_width, r_period;
    logic [31:0]          r_sum;
    logic [ERR_BITS-1:0]  r_err;
    logic [CNT_WIDTH-1:0] r_prev_w, r_prev_h, r_prev_p;
    logic [SW-1:0]        r_stab;
    logic [CNT_WIDTH-1:0] r_out_width, r_out_height, r_out_period;
    logic [31:0]          r_out_sum;
    logic [15:0]          r_out_fc;
    logic [ERR_BITS-1:0]  r_out_err;
    logic                 r_update;

    assign w_ls      = de_i & hs_i;
    assign w_fs      = w_ls & vs_i;
    assign w_vs_err  = de_i & vs_i & ~hs_i;
    assign w_measure = (r_state == MEASURE);
    // Pixel and clock counters restart on every line start once measuring, but only on a frame start before that.
    assign w_restart = w_measure ? w_ls : w_fs;

    video_meter_satcnt #(.W(CNT_WIDTH)) u_pix_cnt (
        .clk(clk), .rst(rst), .i_load(w_restart), .i_load_val(CNT_WIDTH'(1)),
        .i_inc(w_measure & de_i), .o_cnt(w_pix_cnt), .o_sat(w_pix_sat)
    );

    video_meter_satcnt #(.W(CNT_WIDTH)) u_line_cnt (
        .clk(clk), .rst(rst), .i_load(w_fs), .i_load_val(CNT_WIDTH'(1)),
        .i_inc(w_measure & w_ls), .o_cnt(w_line_cnt), .o_sat(w_line_sat)
    );

    video_meter_satcnt #(.W(CNT_WIDTH)) u_clk_cnt (
        .clk(clk), .rst(rst), .i_load(w_restart), .i_load_val(CNT_WIDTH'(1)),
        .i_inc(w_measure), .o_cnt(w_clk_cnt), .o_sat(w_clk_sat)
    );

    assign w_first_line   = (w_line_cnt == CNT_WIDTH'(1));
    assign w_close_width  = w_first_line ? w_pix_cnt : r_width;
    assign w_close_period = !w_first_line ? r_period : (w_fs ? '0 : w_clk_cnt);

    // NOTE: every variable gets a default before any condition, so no latch can be inferred.
    always_comb begin
        w_err_next = r_err;
        if (w_measure) begin
            if (w_vs_err) w_err_next[ERR_VS] = 1'b1;
            if (w_pix_sat || w_line_sat || w_clk_sat) w_err_next[ERR_SAT] = 1'b1;
            if (w_ls && !w_first_line && (w_pix_cnt != r_width)) w_err_next[ERR_WIDTH] = 1'b1;
        end
    end

    assign w_same_geom = (w_close_width == r_prev_w) && (w_line_cnt == r_prev_h) &&
                         (w_close_period == r_prev_p) && (w_err_next == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= WAIT_VS;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_measure && w_fs) w_state_next = MEASURE;
    end

    // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width      <= '0;
            r_period     <= '0;
            r_sum        <= '0;
            r_err        <= '0;
            r_prev_w     <= '0;
            r_prev_h     <= '0;
            r_prev_p     <= '0;
            r_stab       <= '0;
            r_out_width  <= '0;
            r_out_height <= '0;
            r_out_period <= '0;
            r_out_sum    <= '0;
            r_out_fc     <= '0;
            r_out_err    <= '0;
            r_update     <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (!w_measure) begin
                if (w_fs) begin
                    r_width  <= '0;
                    r_period <= '0;
                    r_sum    <= 32'(di_i);
                    r_err    <= '0;
                end
            end else if (w_fs) begin
                r_out_width  <= w_close_width;
                r_out_height <= w_line_cnt;
                r_out_period <= w_close_period;
                r_out_sum    <= r_sum;
                r_out_err    <= w_err_next;
                r_out_fc     <= r_out_fc + 16'd1;
                r_update     <= 1'b1;
                r_prev_w     <= w_close_width;
                r_prev_h     <= w_line_cnt;
                r_prev_p     <= w_close_period;
                if (!w_same_geom)                         r_stab <= '0;
                else if (r_stab != SW'(STABLE_FRAMES))    r_stab <= r_stab + SW'(1);
                r_width      <= '0;
                r_period     <= '0;
                r_sum        <= 32'(di_i);
                r_err        <= '0;
            end else begin
                if (w_ls && w_first_line) begin
                    r_width  <= w_pix_cnt;
                    r_period <= w_clk_cnt;
                end
                if (de_i) r_sum <= r_sum + 32'(di_i);
                r_err <= w_err_next;
            end
        end
    end

    assign width_o     = r_out_width;
    assign height_o    = r_out_height;
    assign line_clk_o  = r_out_period;
    assign sum_o       = r_out_sum;
    assign frame_cnt_o = r_out_fc;
    assign err_o       = r_out_err;
    assign update_o    = r_update;
    assign locked_o    = (r_stab == SW'(STABLE_FRAMES));

endmodule

// File: tb/tb_video_stream_meter.sv
// Self-checking bench: frame-level reference model fed from the driven stimulus, two DUT widths.
module tb_video_stream_meter;

    logic        clk, rst, de_i, hs_i, vs_i;
    logic [11:0] di_i;

    logic [15:0] w16, h16, p16, fc16;
    logic [31:0] s16;
    logic [2:0]  e16;
    logic        u16, l16;
    logic [3:0]  w4, h4, p4;
    logic [15:0] fc4;
    logic [31:0] s4;
    logic [2:0]  e4;
    logic        u4, l4;

    video_stream_meter #(.PIXEL_WIDTH(12), .CNT_WIDTH(16), .STABLE_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .width_o(w16), .height_o(h16), .line_clk_o(p16), .sum_o(s16), .frame_cnt_o(fc16),
        .err_o(e16), .update_o(u16), .locked_o(l16)
    );

    video_stream_meter #(.PIXEL_WIDTH(12), .CNT_WIDTH(4), .STABLE_FRAMES(2)) dut4 (
        .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .width_o(w4), .height_o(h4), .line_clk_o(p4), .sum_o(s4), .frame_cnt_o(fc4),
        .err_o(e4), .update_o(u4), .locked_o(l4)
    );

    typedef struct {
        int          width, height, period;
        logic [31:0] sum;
        logic [2:0]  err;
        int          stab, pw, ph, pp;
    } mstate_t;

    int          checks = 0, failures = 0;
    int          cyc = 0, upd16_cnt = 0, upd4_cnt = 0, exp_upd = 0;
    bit          in_frame;
    int          lens[$];
    int          starts[$];
    logic [31:0] cur_sum;
    bit          cur_vserr;
    mstate_t     m16, m4;
    logic [15:0] exp_fc;

    logic [99:0] act16;
    logic [63:0] act4;
    assign act16 = {w16, h16, p16, s16, e16, fc16, l16};
    assign act4  = {w4, h4, p4, s4, e4, fc4, l4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (u16) upd16_cnt++;
        if (u4)  upd4_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Closes the recorded frame for a meter whose counters top out at maxv.
    function automatic mstate_t close_model(input mstate_t s, input int maxv, input int close_cyc);
        mstate_t r;
        int n, gap;
        r = s;
        n = lens.size();
        r.width  = imin(lens[0], maxv);
        r.height = imin(n, maxv);
        r.period = (n > 1) ? imin(starts[1] - starts[0], maxv) : 0;
        r.sum    = cur_sum;
        r.err    = 3'b000;
        r.err[2] = cur_vserr;
        if (n >= maxv) r.err[1] = 1'b1;
        for (int i = 0; i < n; i++) begin
            gap = ((i + 1 < n) ? starts[i + 1] : close_cyc) - starts[i];
            if (lens[i] >= maxv || gap >= maxv) r.err[1] = 1'b1;
            if (i > 0 && imin(lens[i], maxv) != r.width) r.err[0] = 1'b1;
        end
        if (r.width == s.pw && r.height == s.ph && r.period == s.pp && r.err == 3'b000)
            r.stab = (s.stab < 2) ? s.stab + 1 : 2;
        else
            r.stab = 0;
        r.pw = r.width;
        r.ph = r.height;
        r.pp = r.period;
        return r;
    endfunction

    function automatic logic [99:0] exp16();
        return {16'(m16.width), 16'(m16.height), 16'(m16.period), m16.sum, m16.err, exp_fc, m16.stab == 2};
    endfunction

    function automatic logic [63:0] exp4();
        return {4'(m4.width), 4'(m4.height), 4'(m4.period), m4.sum, m4.err, exp_fc, m4.stab == 2};
    endfunction

    task automatic model_reset();
        m16 = '{default: 0};
        m4  = '{default: 0};
        exp_fc = '0;
        in_frame = 1'b0;
        lens.delete();
        starts.delete();
    endtask

    // One pixel occupying gap cycles; idle cycles carry random, unqualified hs/vs/di.
    task automatic px(input logic [11:0] d, input bit h, input bit v, input int gap);
        di_i = d; de_i = 1'b1; hs_i = h; vs_i = v;
        if (h && v) begin
            if (in_frame) begin
                m16 = close_model(m16, 65535, cyc);
                m4  = close_model(m4, 15, cyc);
                exp_fc++;
                exp_upd++;
            end
            lens.delete();
            starts.delete();
            lens.push_back(1);
            starts.push_back(cyc);
            cur_sum = 32'(d);
            cur_vserr = 1'b0;
            in_frame = 1'b1;
        end else if (in_frame) begin
            if (h) begin
                lens.push_back(1);
                starts.push_back(cyc);
            end else begin
                lens[lens.size() - 1] = lens[lens.size() - 1] + 1;
            end
            cur_sum += 32'(d);
            if (v && !h) cur_vserr = 1'b1;
        end
        @(posedge clk); cyc++; #1;
        de_i = 1'b0; hs_i = 1'($urandom); vs_i = 1'($urandom); di_i = 12'($urandom);
        repeat (gap - 1) begin
            @(posedge clk); cyc++; #1;
        end
    endtask

    task automatic frame(input int nl, input int ppl, input int sp, input int odd_line, input int odd_len,
                         input int vs_line, input int vs_x, input bit xidx);
        int len;
        for (int l = 0; l < nl; l++) begin
            len = (l == odd_line) ? odd_len : ppl;
            for (int x = 0; x < len; x++)
                px(xidx ? 12'(x) : 12'($urandom), x == 0, (x == 0 && l == 0) || (l == vs_line && x == vs_x), sp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; di_i = '0;
        repeat (4) begin
            @(posedge clk); cyc++;
        end
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (act16 !== exp16()) begin
            failures++; $display("FAIL reset_outputs16: got %h expected %h", act16, exp16());
        end
        checks++;
        if (act4 !== exp4() || u16 !== 1'b0) begin
            failures++; $display("FAIL reset_outputs4: got %h upd %b expected %h upd 0", act4, u16, exp4());
        end
    endtask

    task automatic test_basic();
        frame(128, 24, 4, -1, 0, -1, -1, 1'b1);
        checks++;
        if (upd16_cnt !== exp_upd || upd4_cnt !== exp_upd) begin
            failures++; $display("FAIL first_start_no_update: got %0d/%0d expected %0d", upd16_cnt, upd4_cnt, exp_upd);
        end
        frame(128, 24, 4, -1, 0, -1, -1, 1'b1);
        checks++;
        if (act16 !== exp16()) begin
            failures++; $display("FAIL basic_frame1: got %h expected %h", act16, exp16());
        end
        checks++;
        if ({w16, h16, p16, s16, e16, fc16} !== {16'd24, 16'd128, 16'd96, 32'd35328, 3'd0, 16'd1}) begin
            failures++; $display("FAIL basic_geometry: got w=%0d h=%0d p=%0d s=%0d e=%b fc=%0d expected 24/128/96/35328/000/1",
                                 w16, h16, p16, s16, e16, fc16);
        end
        checks++;
        if (act4 !== exp4() || w4 !== 4'd15 || e4[1] !== 1'b1) begin
            failures++; $display("FAIL sat_width4: got %h expected %h (width 15, err[1] set)", act4, exp4());
        end
        frame(128, 24, 4, -1, 0, -1, -1, 1'b1);
        checks++;
        if (act16 !== exp16() || l16 !== 1'b0) begin
            failures++; $display("FAIL basic_frame2: got %h expected %h", act16, exp16());
        end
    endtask

    task automatic test_lock();
        frame(4, 20, 1, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || l16 !== 1'b1) begin
            failures++; $display("FAIL lock_set: got %h lock %b expected %h lock 1", act16, l16, exp16());
        end
        frame(3, 20, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || l16 !== 1'b0) begin
            failures++; $display("FAIL lock_drop: got %h lock %b expected %h lock 0", act16, l16, exp16());
        end
    endtask

    task automatic test_width_err();
        frame(6, 24, 2, 3, 23, -1, -1, 1'b0);
        frame(6, 24, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || e16[0] !== 1'b1 || w16 !== 16'd24) begin
            failures++; $display("FAIL width_err: got %h expected %h (err[0] set, width 24)", act16, exp16());
        end
        checks++;
        if (act4 !== exp4()) begin
            failures++; $display("FAIL width_err4: got %h expected %h", act4, exp4());
        end
        frame(6, 24, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || e16 !== 3'b000) begin
            failures++; $display("FAIL width_clean: got %h expected %h", act16, exp16());
        end
    endtask

    task automatic test_vs_err();
        frame(6, 24, 2, -1, 0, 2, 5, 1'b0);
        frame(6, 24, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || e16 !== 3'b100 || {w16, h16, p16} !== {16'd24, 16'd6, 16'd48}) begin
            failures++; $display("FAIL vs_err: got %h expected %h (err 100, 24/6/48)", act16, exp16());
        end
        frame(6, 24, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || e16 !== 3'b000) begin
            failures++; $display("FAIL vs_clean: got %h expected %h", act16, exp16());
        end
    endtask

    task automatic test_single_line();
        frame(1, 10, 3, -1, 0, -1, -1, 1'b0);
        frame(2, 8, 1, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || {w16, h16, p16} !== {16'd10, 16'd1, 16'd0}) begin
            failures++; $display("FAIL single_line: got %h expected %h (10/1/0)", act16, exp16());
        end
    endtask

    task automatic test_random();
        int nl, ppl;
        for (int k = 0; k < 8; k++) begin
            nl  = $urandom_range(1, 8);
            ppl = $urandom_range(1, 20);
            frame(nl, ppl, $urandom_range(1, 3), $urandom_range(0, nl), $urandom_range(1, 20),
                  $urandom_range(0, nl), $urandom_range(1, 20), 1'b0);
            checks++;
            if (act16 !== exp16() || act4 !== exp4()) begin
                failures++; $display("FAIL random_%0d: got %h / %h expected %h / %h", k, act16, act4, exp16(), exp4());
            end
        end
        checks++;
        if (upd16_cnt !== exp_upd || upd4_cnt !== exp_upd) begin
            failures++; $display("FAIL update_count: got %0d/%0d expected %0d", upd16_cnt, upd4_cnt, exp_upd);
        end
    endtask

    task automatic test_reset_mid();
        frame(2, 10, 1, -1, 0, -1, -1, 1'b0);
        rst = 1'b1; de_i = 1'b0;
        @(posedge clk); cyc++; #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (act16 !== exp16() || act4 !== exp4()) begin
            failures++; $display("FAIL reset_mid_zero: got %h / %h expected %h / %h", act16, act4, exp16(), exp4());
        end
        frame(3, 12, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (upd16_cnt !== exp_upd || upd4_cnt !== exp_upd) begin
            failures++; $display("FAIL reset_mid_no_update: got %0d/%0d expected %0d", upd16_cnt, upd4_cnt, exp_upd);
        end
        frame(3, 12, 2, -1, 0, -1, -1, 1'b0);
        checks++;
        if (act16 !== exp16() || fc16 !== 16'd1 || upd16_cnt !== exp_upd) begin
            failures++; $display("FAIL reset_mid_update: got %h fc %0d expected %h fc 1", act16, fc16, exp16());
        end
    endtask

    initial begin
        rst = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; di_i = '0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_lock();
        test_width_err();
        test_vs_err();
        test_single_line();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
